relu_maxpool_2x2: RTL and testbench

- Streaming post-processing stage directly downstream of the 5x5 convolution top.
- Consumes the signed double-width convolution results, one per valid cycle in raster order, and applies ReLU.
- Applies 2x2 stride-2 max-pooling, then requantizes the pooled value to a word_length result by right shift with saturation.
- Emits a half-resolution feature map as a valid-qualified stream, with a done pulse on the last pooled pixel of each frame.

---
 rtl/cnn_pkg.sv | 29 ++
 rtl/pool_row_buf.sv | 29 ++
 rtl/relu_maxpool_2x2.sv | 119 +++++++++++
 tb/tb_relu_maxpool_2x2.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizing helpers and types for the CNN post-processing stages.
//   fmap_size()  - feature-map edge length produced by the convolution top
//   sat_max()    - largest positive value of a signed word
//   POOL_SIZE    - pooled map edge length at default sizing
//   acc_t        - signed double-width convolution result
//   pool_state_t - debug state of the pooling stage
package cnn_pkg;

  localparam int DOUBLE_WORD_LENGTH = 16;

  typedef logic signed [DOUBLE_WORD_LENGTH-1:0] acc_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } pool_state_t;

  // Even kernels trim kernel_size pixels, odd kernels trim kernel_size-1.
  function automatic int fmap_size(input int image_size, input int kernel_size);
    return image_size - (kernel_size - (kernel_size % 2));
  endfunction

  function automatic int sat_max(input int word_length);
    return (1 << (word_length - 1)) - 1;
  endfunction

  localparam int POOL_SIZE = fmap_size(36, 5) / 2;

endpackage

// File: rtl/pool_row_buf.sv
// pool_row_buf: one row of horizontal maxima kept between the even and odd
// rows of a pooling band. Synchronous write, asynchronous read on the same
// index, so it maps onto LUTRAM.
//   clk   - rising-edge clock
//   we    - write enable
//   idx   - entry index (shared by read and write)
//   wdata - value written when we=1
//   rdata - current contents of entry idx
module pool_row_buf #(
  parameter int depth = 16,
  parameter int width = 16,
  parameter int idx_w = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [idx_w-1:0] idx,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU, 2x2 stride-2 max-pool and shift/saturate requantize
// on the raster-order output stream of the convolution top.
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset
//   in_valid  - data_in carries a convolution result this cycle
//   data_in   - signed double-width convolution result
//   data_out  - pooled, requantized value (MSB always 0), held between pulses
//   out_valid - one-cycle pulse per pooled pixel
//   done      - pulses with the out_valid of the last pooled pixel of a frame
//
// state  | meaning
// IDLE   | no sample of the current frame accepted yet
// ACTIVE | frame in progress (debug only, datapath ignores it)
module relu_maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int kernel_size        = 5,
  parameter int image_size         = 36,
  parameter int out_shift          = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic signed [double_word_length-1:0] data_in,
  output logic        [word_length-1:0]        data_out,
  output logic                                 out_valid,
  output logic                                 done
);

  localparam int FMAP = fmap_size(image_size, kernel_size);
  localparam int POOL = FMAP / 2;
  localparam int CW   = (FMAP > 2) ? $clog2(FMAP) : 1;
  localparam int IW   = (POOL > 2) ? $clog2(POOL) : 1;
  localparam int DW   = double_word_length;

  localparam logic [CW-1:0] LAST_IDX = CW'(FMAP - 1);
  localparam logic [DW-1:0] SAT      = DW'(sat_max(word_length));

  if (FMAP % 2 != 0) begin : g_bad_cfg
    $error("relu_maxpool_2x2: feature-map size must be even");
  end

  pool_state_t   state;
  logic [CW-1:0] col_cnt;
  logic [CW-1:0] row_cnt;
  logic [DW-1:0] pair_reg;
  logic [DW-1:0] relu_val;
  logic [DW-1:0] hmax;
  logic [DW-1:0] buf_rdata;
  logic [DW-1:0] pmax;
  logic [DW-1:0] shifted;
  logic [IW-1:0] row_idx;
  logic          row_we;
  logic          col_last;
  logic          row_last;

  // After ReLU every value is non-negative, so unsigned compares are exact.
  assign relu_val = data_in[DW-1] ? '0 : data_in;
  assign hmax     = (relu_val > pair_reg) ? relu_val : pair_reg;
  assign pmax     = (buf_rdata > hmax) ? buf_rdata : hmax;
  assign shifted  = pmax >> out_shift;

  assign col_last = (col_cnt == LAST_IDX);
  assign row_last = (row_cnt == LAST_IDX);
  assign row_idx  = IW'(col_cnt >> 1);
  assign row_we   = !rst && in_valid && col_cnt[0] && !row_cnt[0];

  pool_row_buf #(
    .depth (POOL),
    .width (DW),
    .idx_w (IW)
  ) u_row_buf (
    .clk   (clk),
    .we    (row_we),
    .idx   (row_idx),
    .wdata (hmax),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      pair_reg  <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (in_valid) begin
        state <= (col_last && row_last) ? ST_IDLE : ST_ACTIVE;

        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end

        if (!col_cnt[0]) begin
          pair_reg <= relu_val;
        end else if (row_cnt[0]) begin
          out_valid <= 1'b1;
          done      <= col_last && row_last;
          data_out  <= (shifted > SAT) ? word_length'(SAT) : shifted[word_length-1:0];
        end
      end
    end
  end

  // A frame always starts from the origin.
  a_idle_at_origin: assert property (@(posedge clk) disable iff (rst)
    (in_valid && state == ST_IDLE) |-> (col_cnt == '0 && row_cnt == '0));

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
module tb_relu_maxpool_2x2;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        in_valid  [2];
  logic [15:0] data_in   [2];
  logic [7:0]  data_out  [2];
  logic        out_valid [2];
  logic        done      [2];

  always #5 clk = ~clk;

  // Instance 0: 8x8 image, 5x5 kernel -> 4x4 feature map. Instance 1: defaults.
  relu_maxpool_2x2 #(
    .word_length(8), .double_word_length(16), .kernel_size(5),
    .image_size(8), .out_shift(4)
  ) dut_s (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .data_in(data_in[0]),
    .data_out(data_out[0]), .out_valid(out_valid[0]), .done(done[0])
  );

  relu_maxpool_2x2 dut_l (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .data_in(data_in[1]),
    .data_out(data_out[1]), .out_valid(out_valid[1]), .done(done[1])
  );

  int fm [2] = '{4, 32};
  int frame [2][32][32];
  int k [2];
  bit nv [2], ndn [2], nrst [2];
  int ndata [2];
  bit ev [2], edn [2];
  int edata [2];
  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;
  int got [$];
  int cnt_l = 0;

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Expected pooled value straight from the stored frame.
  function automatic int pooled(input int i, input int pr, input int pc);
    int m = 0;
    int q;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (relu(frame[i][2*pr+dr][2*pc+dc]) > m) m = relu(frame[i][2*pr+dr][2*pc+dc]);
    q = m / 16;
    if (q > 127) q = 127;
    return q;
  endfunction

  task automatic step(input int i, input bit v, input int d);
    int r, c;
    @(posedge clk); #1;
    rst[i] = 1'b0;
    in_valid[i] = v;
    data_in[i] = 16'(d);
    if (v) begin
      r = k[i] / fm[i];
      c = k[i] % fm[i];
      frame[i][r][c] = d;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        nv[i] = 1'b1;
        ndata[i] = pooled(i, r / 2, c / 2);
        ndn[i] = (k[i] == fm[i] * fm[i] - 1);
      end
      k[i] = (k[i] + 1) % (fm[i] * fm[i]);
    end
  endtask

  task automatic rst_pulse(input int i);
    @(posedge clk); #1;
    rst[i] = 1'b1;
    in_valid[i] = 1'b0;
    k[i] = 0;
    nv[i] = 1'b0;
    nrst[i] = 1'b1;
  endtask

  task automatic check_got(input string name, input int e[$]);
    bit bad = (got.size() != e.size());
    vectors++;
    if (!bad)
      foreach (e[j]) if (got[j] != e[j]) bad = 1'b1;
    if (bad) begin
      miscompares++;
      $display("FAIL %s: got %p, want %p", name, got, e);
    end
    got.delete();
  endtask

  // Advance expectations: what was computed for the sample just accepted
  // becomes visible on the outputs after this edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (nrst[i]) begin
        ev[i] = 1'b0;
        edn[i] = 1'b0;
        edata[i] = 0;
        nrst[i] = 1'b0;
      end else begin
        ev[i] = nv[i];
        edn[i] = nv[i] && ndn[i];
        if (nv[i]) edata[i] = ndata[i];
      end
      nv[i] = 1'b0;
      ndn[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (out_valid[i] !== ev[i] || done[i] !== edn[i] || data_out[i] !== 8'(edata[i])) begin
          miscompares++;
          $display("FAIL out%0d t=%0t: got valid=%b done=%b data=%0d, want valid=%b done=%b data=%0d",
                   i, $time, out_valid[i], done[i], data_out[i], ev[i], edn[i], edata[i]);
        end
      end
      if (out_valid[0] === 1'b1) got.push_back(int'(data_out[0]));
      if (out_valid[1] === 1'b1) cnt_l++;
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      in_valid[i] = 1'b0;
      data_in[i] = '0;
      k[i] = 0;
      nv[i] = 1'b0;
      ndn[i] = 1'b0;
      nrst[i] = 1'b1;
      ev[i] = 1'b0;
      edn[i] = 1'b0;
      edata[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_en = 1'b1;

    // Ramp
    for (int i = 0; i < 16; i++) step(0, 1'b1, 16 * i);
    repeat (2) step(0, 1'b0, 0);
    check_got("ramp", {5, 7, 13, 15});
    vectors++;
    if (pooled(0, 1, 1) != 15) begin
      miscompares++;
      $display("FAIL model_ramp_11: got %0d, want 15", pooled(0, 1, 1));
    end

    // All negative
    for (int i = 0; i < 16; i++) step(0, 1'b1, -100);
    repeat (2) step(0, 1'b0, 0);
    check_got("negative", {0, 0, 0, 0});

    // Saturation
    for (int i = 0; i < 16; i++) step(0, 1'b1, 32767);
    repeat (2) step(0, 1'b0, 0);
    check_got("sat_full", {127, 127, 127, 127});
    for (int i = 0; i < 16; i++) step(0, 1'b1, (i == 0) ? 2032 : (i == 2) ? 256 : 0);
    repeat (2) step(0, 1'b0, 0);
    check_got("sat_edge", {127, 16, 0, 0});

    // Bubbles
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, 16 * i);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step(0, 1'b0, 0);
    end
    repeat (2) step(0, 1'b0, 0);
    check_got("bubbles", {5, 7, 13, 15});

    // Reset mid-frame
    for (int i = 0; i < 7; i++) step(0, 1'b1, 16 * i);
    rst_pulse(0);
    got.delete();
    for (int i = 0; i < 16; i++) step(0, 1'b1, 16 * i);
    repeat (2) step(0, 1'b0, 0);
    check_got("reset_mid", {5, 7, 13, 15});

    // Back-to-back frames
    for (int i = 0; i < 16; i++) step(0, 1'b1, 16 * i);
    for (int i = 0; i < 16; i++) step(0, 1'b1, 16 * (15 - i));
    repeat (2) step(0, 1'b0, 0);
    check_got("back_to_back", {5, 7, 13, 15, 15, 13, 7, 5});

    // Default sizing, two random frames with occasional bubbles
    for (int i = 0; i < 2048; i++) begin
      step(1, 1'b1, int'($urandom_range(0, 8191)) - 2048);
      if ($urandom_range(0, 15) == 0) step(1, 1'b0, 0);
    end
    repeat (3) step(1, 1'b0, 0);
    vectors++;
    if (cnt_l != 512) begin
      miscompares++;
      $display("FAIL large_count: got %0d outputs, want 512", cnt_l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
